// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared FSM state encoding and error codes for rx_frame_ctrl
package rx_frame_pkg;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
endpackage

// File: rtl/rx_gap_timer.sv
// rx_gap_timer: counts idle cycles between bytes, pulses expired when the gap reaches GAP_CYCLES-1
//   clk, rst   clock, synchronous active-high reset
//   clr_i      zero the counter (takes priority over en_i)
//   en_i       count this cycle
//   expired_o  combinational pulse in the idle cycle that brings the count to GAP_CYCLES-1
module rx_gap_timer #(
    parameter int GAP_CYCLES = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(GAP_CYCLES);
    localparam logic [W-1:0] LAST = W'(GAP_CYCLES - 2);
    logic [W-1:0] gap_q;
    assign expired_o = en_i && gap_q == LAST;
    always_ff @(posedge clk) begin
        if (rst || clr_i) gap_q <= '0;
        else if (en_i) gap_q <= gap_q + 1'b1;
    end
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: assembles FRAME_LEN UART bytes into a frame, drops on gap timeout, hands off via valid/ready
//   rx_done/rx_data          byte strobe and byte from the UART RX core
//   frame_valid/frame_ready  downstream handshake; frame_data byte k at [8k+7:8k]
//   frame_err/err_code       1-cycle discard pulse with reason (01 timeout, 10 checksum)
//   overrun                  1-cycle pulse when a byte arrives while a frame is held
//   frame_cnt                delivered-frame counter, wraps
//   Optional: define RX_CHECKSUM_EN to treat the last byte as a mod-256 sum of the others
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int FRAME_LEN  = 4,
    parameter int GAP_CYCLES = 400,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_done,
    input  logic [7:0]             rx_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [8*FRAME_LEN-1:0] frame_data,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   overrun,
    output logic [CNT_W-1:0]       frame_cnt
);
    localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    logic [1:0] state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, widx;
    logic [8*FRAME_LEN-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic gap_en, expired, timeout, hs, take, start, last, csum_bad;
    assign gap_en  = state_q == S_COLLECT && !rx_done;
    rx_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!gap_en),
        .en_i     (gap_en),
        .expired_o(expired)
    );
    assign timeout = expired && !rst;
    assign hs      = state_q == S_HOLD && frame_ready;
    // A byte is accepted everywhere except while a frame is held and not being taken.
    assign take    = rx_done && (state_q != S_HOLD || frame_ready);
    assign start   = take && state_q != S_COLLECT;
    assign last    = idx_q == IDX_W'(FRAME_LEN - 1);
    assign widx    = start ? '0 : idx_q;
`ifdef RX_CHECKSUM_EN
    logic [7:0] csum_q;
    assign csum_bad = !rst && state_q == S_COLLECT && rx_done && last && rx_data != csum_q;
    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else if (start) csum_q <= rx_data;
        else if (state_q == S_COLLECT && rx_done) csum_q <= csum_q + rx_data;
    end
`else
    assign csum_bad = 1'b0;
`endif
    assign state_d = start ? (FRAME_LEN == 1 ? S_HOLD : S_COLLECT)
                   : state_q == S_COLLECT ? (timeout || csum_bad ? S_IDLE : rx_done && last ? S_HOLD : S_COLLECT)
                   : hs ? S_IDLE : state_q;
    assign idx_d   = start ? IDX_W'(1)
                   : state_q != S_COLLECT || timeout ? '0
                   : rx_done && !last ? idx_q + 1'b1 : idx_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_q + CNT_W'(hs);
            if (take) data_q[widx*8 +: 8] <= rx_data;
        end
    end
    assign frame_valid = state_q == S_HOLD;
    assign frame_data  = data_q;
    assign frame_cnt   = cnt_q;
    assign frame_err   = timeout || csum_bad;
    assign err_code    = timeout ? ERR_TIMEOUT : csum_bad ? ERR_CSUM : ERR_NONE;
    assign overrun     = !rst && state_q == S_HOLD && rx_done && !frame_ready;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed stimulus with a scoreboard monitor for rx_frame_ctrl
module tb_rx_frame_ctrl;
    logic clk = 0, rst = 1, rx_done = 0, frame_ready = 1;
    logic [7:0] rx_data = 0;
    logic frame_valid, frame_err, overrun;
    logic [31:0] frame_data;
    logic [1:0] err_code, frame_cnt;
    rx_frame_ctrl #(.FRAME_LEN(4), .GAP_CYCLES(400), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    typedef struct packed {logic [31:0] data; logic [1:0] cnt;} frm_t;
    frm_t exp_frm[$];
    logic [1:0] exp_err[$];
    logic [31:0] exp_ovr[$];
    logic [1:0] model_cnt = 0;
    int n_chk = 0, n_pass = 0;
    frm_t mf;
    logic [1:0] me;
    logic [31:0] mo;
    logic cnt_pend = 0;
    logic [1:0] cnt_exp;
    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask
    task automatic unexpected(string name, logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %h, expected no event", name, act);
    endtask
    always @(negedge clk) begin
        if (cnt_pend) begin
            check("frame_cnt", {30'b0, frame_cnt}, {30'b0, cnt_exp});
            cnt_pend = 0;
        end
        if (frame_valid && frame_ready) begin
            if (exp_frm.size() == 0) unexpected("frame", frame_data);
            else begin
                mf = exp_frm.pop_front();
                check("frame_data", frame_data, mf.data);
                cnt_pend = 1;
                cnt_exp = mf.cnt;
            end
        end
        if (frame_err) begin
            if (exp_err.size() == 0) unexpected("frame_err", {30'b0, err_code});
            else begin
                me = exp_err.pop_front();
                check("err_code", {30'b0, err_code}, {30'b0, me});
            end
        end
        if (overrun) begin
            if (exp_ovr.size() == 0) unexpected("overrun", frame_data);
            else begin
                mo = exp_ovr.pop_front();
                check("overrun_hold_data", frame_data, mo);
            end
        end
    end
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_byte(logic [7:0] b);
        rx_done = 1;
        rx_data = b;
        step(1);
        rx_done = 0;
    endtask
    task automatic expect_frame(logic [31:0] w, output bit ok);
        ok = 1;
`ifdef RX_CHECKSUM_EN
        if (8'(w[7:0] + w[15:8] + w[23:16]) != w[31:24]) begin
            exp_err.push_back(2'b10);
            ok = 0;
        end
`endif
        if (ok) begin
            model_cnt = model_cnt + 1;
            exp_frm.push_back('{data: w, cnt: model_cnt});
        end
    endtask
    task automatic send_frame(logic [31:0] w, int gap);
        bit ok;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) expect_frame(w, ok);
            send_byte(w[8*k +: 8]);
            if (k < 3) step(gap);
        end
        @(negedge clk);
        check("valid_after_last", {31'b0, frame_valid}, {31'b0, ok});
        step(1);
    endtask
    initial begin
        step(2);
        rst = 0;
        @(negedge clk);
        check("rst_valid", {31'b0, frame_valid}, 0);
        check("rst_data", frame_data, 0);
        check("rst_cnt", {30'b0, frame_cnt}, 0);
        check("rst_err", {29'b0, frame_err, err_code}, 0);
        step(1);
        send_frame(32'h44332211, 9);
        send_frame(32'h06030201, 2);
        send_byte(8'h01);
        step(3);
        send_byte(8'h02);
        exp_err.push_back(2'b01);
        step(397);
        @(negedge clk);
        check("no_early_timeout", {31'b0, frame_err}, 0);
        step(1);
        @(negedge clk);
        check("timeout_cycle399", {29'b0, frame_err, err_code}, 3'b101);
        step(1);
        send_frame(32'h1E0F0A05, 1);
        send_frame(32'h06030201, 398);
        frame_ready = 0;
        send_frame(32'h0C050403, 3);
        exp_ovr.push_back(32'h0C050403);
        send_byte(8'h55);
        @(negedge clk);
        check("held_valid", {31'b0, frame_valid}, 1);
        step(1);
        frame_ready = 1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        expect_frame(32'h31CCBBAA, mf.data[0]);
        send_byte(8'h31);
        step(3);
        send_frame(32'h07030201, 2);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        rst = 1;
        step(1);
        rst = 0;
        model_cnt = 0;
        @(negedge clk);
        check("midrst_valid", {31'b0, frame_valid}, 0);
        check("midrst_data", frame_data, 0);
        check("midrst_cnt", {30'b0, frame_cnt}, 0);
        check("midrst_pulses", {28'b0, frame_err, err_code, overrun}, 0);
        step(1);
        send_frame(32'h60302010, 2);
        for (int i = 0; i < 4; i++) send_frame(32'h0B080201 + 32'h01000001 * i, 1);
        step(5);
        check("wrap_cnt", {30'b0, frame_cnt}, {30'b0, model_cnt});
        check("frames_left", exp_frm.size(), 0);
        check("errs_left", exp_err.size(), 0);
        check("overruns_left", exp_ovr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
